// File: rtl/uart_rx_fifo_reader.sv
// rtl/uart_rx_fifo_reader.sv - buffered UART receive reader for the CPU load path
// Drains UART bytes into a FIFO and returns status/data/count/error words on CPU loads.
module uart_rx_fifo_reader #(
   parameter int         FIFO_DEPTH  = 8,
   parameter int         DATA_W      = 8,
   parameter logic [3:0] BASE_NIBBLE = 4'h8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       addr,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] uart_data,
   input  logic              uart_data_valid,
   output logic              uart_data_ready,
   input  logic              tx_ready,
   output logic              is_uart_load,
   output logic [31:0]       rd_data,
   output logic              rx_nonempty
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_ERR    = 2'd3;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              underflow;
   logic [7:0]        overflow_cnt;
   logic              held;

   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   logic [1:0] reg_sel;
   logic       status_rd;
   logic       data_rd;
   logic       err_rd;
   logic       ovf_event;
   logic       unused_addr;

   assign unused_addr = ^{addr[27:4], addr[1:0]};

   assign full            = (count == FULL_COUNT);
   assign empty           = (count == '0);
   assign uart_data_ready = !full;
   assign rx_nonempty     = !empty;

   assign is_uart_load = rd_en && (addr[31:28] == BASE_NIBBLE);
   assign reg_sel      = addr[3:2];
   assign status_rd    = is_uart_load && (reg_sel == REG_STATUS);
   assign data_rd      = is_uart_load && (reg_sel == REG_DATA);
   assign err_rd       = is_uart_load && (reg_sel == REG_ERR);

   assign push = uart_data_valid && !full;
   assign pop  = data_rd && !empty;

   // A byte offered while full and then withdrawn before acceptance is lost.
   assign ovf_event = held && !uart_data_valid;

   always_comb begin
      rd_data = '0;
      if (is_uart_load) begin
         case (reg_sel)
            REG_STATUS: rd_data = {16'h0, 8'(count), 4'h0, full, underflow, rx_nonempty, tx_ready};
            REG_DATA:   if (!empty) rd_data = 32'(mem[rd_ptr]);
            REG_COUNT:  rd_data = 32'(count);
            default:    rd_data = {24'h0, overflow_cnt};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= uart_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         underflow    <= 1'b0;
         overflow_cnt <= 8'd0;
         held         <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         if (data_rd && empty)
            underflow <= 1'b1;
         else if (status_rd)
            underflow <= 1'b0;

         held <= uart_data_valid && full;

         if (err_rd)
            overflow_cnt <= ovf_event ? 8'd1 : 8'd0;
         else if (ovf_event && (overflow_cnt != 8'hFF))
            overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_reader.sv
// tb/tb_uart_rx_fifo_reader.sv - self-checking bench for uart_rx_fifo_reader
// Queue-based reference model compared every cycle, plus directed literal expectations.
module tb_uart_rx_fifo_reader;

   localparam int DEPTH = 8;
   localparam logic [31:0] A_STATUS = 32'h8000_0000;
   localparam logic [31:0] A_DATA   = 32'h8000_0004;
   localparam logic [31:0] A_COUNT  = 32'h8000_0008;
   localparam logic [31:0] A_ERR    = 32'h8000_000C;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        rd_en;
   logic [7:0]  uart_data;
   logic        uart_data_valid;
   logic        uart_data_ready;
   logic        tx_ready;
   logic        is_uart_load;
   logic [31:0] rd_data;
   logic        rx_nonempty;

   int checks = 0;
   int errors = 0;

   uart_rx_fifo_reader #(.FIFO_DEPTH(DEPTH), .DATA_W(8), .BASE_NIBBLE(4'h8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .addr(addr),
      .rd_en(rd_en),
      .uart_data(uart_data),
      .uart_data_valid(uart_data_valid),
      .uart_data_ready(uart_data_ready),
      .tx_ready(tx_ready),
      .is_uart_load(is_uart_load),
      .rd_data(rd_data),
      .rx_nonempty(rx_nonempty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] mq[$];
   bit         m_und;
   int         m_ovf;
   bit         m_held;

   function automatic bit m_load();
      return rd_en && (addr[31:28] == 4'h8);
   endfunction

   function automatic logic [31:0] exp_rd();
      int n;
      n = mq.size();
      if (!m_load()) return 32'h0;
      case (addr[3:2])
         2'd0: return {16'h0, 8'(n), 4'h0, (n == DEPTH), m_und, (n != 0), tx_ready};
         2'd1: return (n != 0) ? 32'(mq[0]) : 32'h0;
         2'd2: return 32'(n);
         default: return 32'(m_ovf);
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_und  = 0;
            m_ovf  = 0;
            m_held = 0;
         end else begin
            bit ld, full, push, pop, ev;
            int sel;
            ld   = m_load();
            sel  = int'(addr[3:2]);
            full = (mq.size() == DEPTH);
            push = uart_data_valid && !full;
            pop  = ld && sel == 1 && mq.size() != 0;
            if (ld && sel == 1 && mq.size() == 0) m_und = 1;
            else if (ld && sel == 0) m_und = 0;
            ev     = m_held && !uart_data_valid;
            m_held = uart_data_valid && full;
            if (ld && sel == 3) m_ovf = ev ? 1 : 0;
            else if (ev && m_ovf < 255) m_ovf++;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(uart_data);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check("cyc_ready",    32'(uart_data_ready), 32'(mq.size() != DEPTH));
         check("cyc_nonempty", 32'(rx_nonempty),     32'(mq.size() != 0));
         check("cyc_load",     32'(is_uart_load),    32'(m_load()));
         check("cyc_rd_data",  rd_data,              exp_rd());
      end
   end

   // One cycle: called at posedge+1, drives inputs, samples at negedge, returns at next posedge+1.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic [31:0] a,
                       output logic [31:0] rdv, output logic rdy, output logic ld);
      uart_data_valid = v;
      uart_data       = d;
      rd_en           = r;
      addr            = a;
      @(negedge clk);
      rdv = rd_data;
      rdy = uart_data_ready;
      ld  = is_uart_load;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      logic [31:0] rv; logic ry, l;
      step(1'b1, d, 1'b0, 32'h0, rv, ry, l);
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rv; logic ry, l;
      step(1'b0, 8'h00, 1'b1, a, rv, ry, l);
      check(name, rv, exp);
   endtask

   task automatic idle();
      logic [31:0] rv; logic ry, l;
      step(1'b0, 8'h00, 1'b0, 32'h0, rv, ry, l);
   endtask

   initial begin
      logic [31:0] rv;
      logic        ry, l;

      rst_n = 1'b0;
      addr = 32'h0; rd_en = 1'b0; uart_data = 8'h0; uart_data_valid = 1'b0; tx_ready = 1'b1;
      #1;
      check("reset_ready",    32'(uart_data_ready), 32'h1);
      check("reset_nonempty", 32'(rx_nonempty),     32'h0);
      check("reset_rd_data",  rd_data,              32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: basic order
      push(8'h41); push(8'h42); push(8'h43);
      rd("t1_count", A_COUNT, 32'd3);
      rd("t1_status", A_STATUS, 32'h0000_0303);
      rd("t1_data0", A_DATA, 32'h41);
      rd("t1_data1", A_DATA, 32'h42);
      rd("t1_data2", A_DATA, 32'h43);
      rd("t1_count_end", A_COUNT, 32'd0);
      check("t1_nonempty", 32'(rx_nonempty), 32'h0);

      // 2: full, held 9th byte, wrap
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      step(1'b1, 8'h18, 1'b1, A_STATUS, rv, ry, l);
      check("t2_status_full", rv, 32'h0000_080B);
      check("t2_ready_full", 32'(ry), 32'h0);
      step(1'b1, 8'h18, 1'b1, A_DATA, rv, ry, l);
      check("t2_pop_head", rv, 32'h10);
      check("t2_ready_pop_cycle", 32'(ry), 32'h0);
      step(1'b1, 8'h18, 1'b0, 32'h0, rv, ry, l);
      check("t2_ready_after_pop", 32'(ry), 32'h1);
      rd("t2_count", A_COUNT, 32'd8);
      for (int i = 0; i < 8; i++) rd("t2_drain", A_DATA, 32'h11 + 32'(i));

      // 3: underflow sticky, cleared by STATUS read
      rd("t3_empty_data", A_DATA, 32'h0);
      rd("t3_status_und", A_STATUS, 32'h0000_0005);
      tx_ready = 1'b0;
      rd("t3_status_clr", A_STATUS, 32'h0000_0000);
      tx_ready = 1'b1;

      // 4: overflow events, clear-on-read, saturation
      for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
      for (int i = 0; i < 3; i++) begin
         push(8'hEE);
         idle();
      end
      rd("t4_err3", A_ERR, 32'd3);
      rd("t4_err_clr", A_ERR, 32'd0);
      for (int i = 0; i < 300; i++) begin
         push(8'hEE);
         idle();
      end
      rd("t4_err_sat", A_ERR, 32'd255);
      push(8'hEE);
      rd("t4_err_clr_ev", A_ERR, 32'd0);
      rd("t4_err_one", A_ERR, 32'd1);
      for (int i = 0; i < 8; i++) rd("t4_drain", A_DATA, 32'h20 + 32'(i));

      // 5: simultaneous push and pop
      push(8'h60); push(8'h61);
      step(1'b1, 8'h55, 1'b1, A_DATA, rv, ry, l);
      check("t5_pushpop_data", rv, 32'h60);
      rd("t5_count2", A_COUNT, 32'd2);
      rd("t5_head", A_DATA, 32'h61);
      rd("t5_tail", A_DATA, 32'h55);
      step(1'b1, 8'h77, 1'b1, A_DATA, rv, ry, l);
      check("t5_empty_push_read", rv, 32'h0);
      rd("t5_status", A_STATUS, 32'h0000_0107);
      rd("t5_count1", A_COUNT, 32'd1);
      rd("t5_stored", A_DATA, 32'h77);

      // 6: foreign window, async reset mid-operation
      push(8'h88);
      step(1'b0, 8'h00, 1'b1, 32'h4000_0004, rv, ry, l);
      check("t6_foreign_rd", rv, 32'h0);
      check("t6_foreign_ld", 32'(l), 32'h0);
      rd("t6_nopop", A_COUNT, 32'd1);
      for (int i = 0; i < 4; i++) push(8'h89 + 8'(i));
      uart_data_valid = 1'b0;
      rd_en = 1'b1;
      addr  = A_COUNT;
      #1;
      check("t6_pre_reset_count", rd_data, 32'd5);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_reset_count", rd_data, 32'd0);
      check("t6_reset_ready", 32'(uart_data_ready), 32'h1);
      check("t6_reset_nonempty", 32'(rx_nonempty), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd("t6_post_count", A_COUNT, 32'd0);
      push(8'h99);
      rd("t6_post_data", A_DATA, 32'h99);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
